// File: rtl/remote_pkg.sv
// remote_pkg: frame constants and transmitter state type shared by both ends of the remote-control link.
//   CUSTOM_W/KEY_W   widths of the custom code and the key code
//   FRAME_BITS       bit periods in one frame (lead + 32 data + end)
//   DATA_BITS        width of the shifted payload {custom, key, ~key}
//   LEAD_LEVEL       line level of the lead bit
//   IDLE_LEVEL       line level while idle and during the end bit
package remote_pkg;
    localparam int CUSTOM_W   = 16;
    localparam int KEY_W      = 8;
    localparam int FRAME_BITS = 34;
    localparam int DATA_BITS  = 32;
    localparam logic LEAD_LEVEL = 1'b0;
    localparam logic IDLE_LEVEL = 1'b1;
    typedef enum logic [1:0] {IDLE, LEAD, DATA, END} tx_state_t;
endpackage

// File: rtl/remote_bit_timer.sv
// remote_bit_timer: divides the clock into bit periods of BIT_CYCLES cycles.
//   Clock   rising-edge clock
//   Reset   synchronous active-high reset, clears the period counter
//   Clear   restarts the period at count 0
//   Enable  counts while high; Tick is suppressed while low
//   Tick    high on the last cycle of each period
module remote_bit_timer #(
    parameter int BIT_CYCLES = 1
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Clear,
    input  logic Enable,
    output logic Tick
);
    localparam int CW = BIT_CYCLES > 1 ? $clog2(BIT_CYCLES) : 1;
    logic [CW-1:0] count;
    // With BIT_CYCLES = 1 the count sits at 0 and every enabled cycle ticks.
    assign Tick = Enable && count == CW'(BIT_CYCLES - 1);
    always_ff @(posedge Clock) begin
        if (Reset || Clear)
            count <= '0;
        else if (Enable)
            count <= Tick ? '0 : count + 1'b1;
    end
endmodule

// File: rtl/remote_transmitter.sv
// remote_transmitter: sends one remote-control frame (lead, custom, key, ~key, end) MSB first per Start request.
//   Clock   rising-edge clock
//   Reset   synchronous active-high reset; aborts any frame in flight
//   Start   transmit request, only honoured while idle
//   Custom  16-bit custom code, latched on accept
//   Tecla   8-bit key code, latched on accept
//   Serial  registered line output, idles high
//   Busy    registered, high for the whole frame
//   Done    registered one-cycle pulse in the first idle cycle after a frame
module remote_transmitter
    import remote_pkg::*;
#(
    parameter int BIT_CYCLES = 1
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Start,
    input  logic [CUSTOM_W-1:0] Custom,
    input  logic [KEY_W-1:0]    Tecla,
    output logic                Serial,
    output logic                Busy,
    output logic                Done
);
    tx_state_t            state;
    logic [DATA_BITS-1:0] shreg;
    logic [4:0]           bit_cnt;
    logic                 tick;
    logic                 accept;

    assign accept = state == IDLE && Start;

    remote_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) timer (
        .Clock  (Clock),
        .Reset  (Reset),
        .Clear  (accept),
        .Enable (state != IDLE),
        .Tick   (tick)
    );

    // The first payload bit leaves on the lead tick, so DATA emits the
    // remaining 31 bits and uses its 32nd tick to move on to the end bit.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= IDLE;
            Serial  <= IDLE_LEVEL;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    state   <= LEAD;
                    shreg   <= {Custom, Tecla, ~Tecla};
                    bit_cnt <= '0;
                    Serial  <= LEAD_LEVEL;
                    Busy    <= 1'b1;
                end
                LEAD: if (tick) begin
                    state  <= DATA;
                    Serial <= shreg[DATA_BITS-1];
                    shreg  <= {shreg[DATA_BITS-2:0], 1'b0};
                end
                DATA: if (tick) begin
                    bit_cnt <= bit_cnt + 5'd1;
                    if (bit_cnt == 5'd31) begin
                        state  <= END;
                        Serial <= IDLE_LEVEL;
                    end else begin
                        Serial <= shreg[DATA_BITS-1];
                        shreg  <= {shreg[DATA_BITS-2:0], 1'b0};
                    end
                end
                END: if (tick) begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                    Done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
